// File: rtl/d_mem_arb.sv
// Arbiter for the shared single-port data memory. The CPU has default priority and the host gets a forced slot after a bounded wait or a bounded locked burst.
// Optional stall statistics counter (STALL_CNT) is enabled with macro D_MEM_ARB_STATS_EN.
module d_mem_arb #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 8
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          CPU_EN,
   input  logic          CPU_WE,
   input  logic [AW-1:0] CPU_ADDR,
   input  logic [DW-1:0] CPU_WDATA,
   output logic [DW-1:0] CPU_RDATA,
   output logic          CPU_STALL,
   input  logic          H_REQ,
   input  logic          H_LOCK,
   input  logic          H_WE,
   input  logic [AW-1:0] H_ADDR,
   input  logic [DW-1:0] H_WDATA,
   output logic          H_GNT,
   output logic [DW-1:0] H_RDATA,
   output logic          MEM_EN,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_WDATA,
   input  logic [DW-1:0] MEM_RDATA
`ifdef D_MEM_ARB_STATS_EN
   ,
   output logic [15:0]   STALL_CNT
`endif
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;

   logic starve;
   logic host_win;
   logic host_sel;
   logic gnt;
   logic stall;
   logic mem_en_raw;
   logic mem_we_raw;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      burst_cnt_d = burst_cnt_q;
      starve      = (wait_cnt_q == WW'(MAX_WAIT));
      host_win    = 1'b0;
      host_sel    = 1'b0;
      gnt         = 1'b0;
      stall       = 1'b0;
      case (state_q)
         ARB: begin
            host_win = H_REQ & (~CPU_EN | starve);
            host_sel = host_win;
            gnt      = host_win;
            stall    = host_win & CPU_EN;
            if (host_win || !H_REQ) begin
               wait_cnt_d = '0;
            end else if (CPU_EN && !starve) begin
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
            if (host_win && H_LOCK) begin
               state_d     = LOCK;
               burst_cnt_d = BW'(1);
            end else begin
               burst_cnt_d = '0;
            end
         end
         LOCK: begin
            host_sel   = 1'b1;
            gnt        = H_REQ;
            stall      = CPU_EN;
            wait_cnt_d = '0;
            if (!H_REQ || !H_LOCK || burst_cnt_q == BW'(MAX_BURST)) begin
               state_d     = ARB;
               burst_cnt_d = '0;
            end else begin
               burst_cnt_d = burst_cnt_q + BW'(1);
            end
         end
         default: begin
            state_d     = ARB;
            wait_cnt_d  = '0;
            burst_cnt_d = '0;
         end
      endcase
      // In ARB a host selection implies H_REQ=1, so H_REQ is the host enable in both states.
      mem_en_raw = host_sel ? H_REQ : CPU_EN;
      mem_we_raw = (host_sel ? H_WE : CPU_WE) & mem_en_raw;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ARB;
         wait_cnt_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Control outputs are forced inactive for as long as reset is held, so an in-flight write is dropped.
   assign H_GNT     = gnt & RST_N;
   assign CPU_STALL = stall & RST_N;
   assign MEM_EN    = mem_en_raw & RST_N;
   assign MEM_WE    = mem_we_raw & RST_N;
   assign MEM_ADDR  = host_sel ? H_ADDR : CPU_ADDR;
   assign MEM_WDATA = host_sel ? H_WDATA : CPU_WDATA;
   assign CPU_RDATA = MEM_RDATA;
   assign H_RDATA   = MEM_RDATA;

`ifdef D_MEM_ARB_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (CPU_STALL && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_d_mem_arb.sv
// Directed bench for d_mem_arb with a small single-port memory model attached to the MEM_* port.
module tb_d_mem_arb;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       CPU_EN, CPU_WE;
   logic [7:0] CPU_ADDR, CPU_WDATA, CPU_RDATA;
   logic       CPU_STALL;
   logic       H_REQ, H_LOCK, H_WE;
   logic [7:0] H_ADDR, H_WDATA, H_RDATA;
   logic       H_GNT;
   logic       MEM_EN, MEM_WE;
   logic [7:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
`ifdef D_MEM_ARB_STATS_EN
   logic [15:0] STALL_CNT;
   logic [15:0] stall_base;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:255];

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
   end
   assign MEM_RDATA = mem[MEM_ADDR];

   d_mem_arb #(.AW(8), .DW(8), .MAX_WAIT(4), .MAX_BURST(8)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .CPU_EN(CPU_EN), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
      .CPU_RDATA(CPU_RDATA), .CPU_STALL(CPU_STALL),
      .H_REQ(H_REQ), .H_LOCK(H_LOCK), .H_WE(H_WE), .H_ADDR(H_ADDR), .H_WDATA(H_WDATA),
      .H_GNT(H_GNT), .H_RDATA(H_RDATA),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RDATA(MEM_RDATA)
`ifdef D_MEM_ARB_STATS_EN
      , .STALL_CNT(STALL_CNT)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge; inputs change here.
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      RST_N = 1'b0;
      CPU_EN = 1'b0; CPU_WE = 1'b0; CPU_ADDR = 8'h00; CPU_WDATA = 8'h00;
      H_REQ = 1'b0; H_LOCK = 1'b0; H_WE = 1'b0; H_ADDR = 8'h00; H_WDATA = 8'h00;

      // Reset state
      next_cycle(); next_cycle();
      #3;
      chk("rst_gnt", H_GNT, 0);
      chk("rst_stall", CPU_STALL, 0);
      chk("rst_men", MEM_EN, 0);
      chk("rst_mwe", MEM_WE, 0);
      next_cycle();
      RST_N = 1'b1;

      // CPU write then read
      next_cycle();
      CPU_EN = 1; CPU_WE = 1; CPU_ADDR = 8'h10; CPU_WDATA = 8'h5A;
      #3;
      $display("cpu write addr=10 data=5A");
      chk("cpuw_mwe", MEM_WE, 1);
      chk("cpuw_men", MEM_EN, 1);
      chk("cpuw_addr", MEM_ADDR, 8'h10);
      chk("cpuw_wdata", MEM_WDATA, 8'h5A);
      chk("cpuw_stall", CPU_STALL, 0);
      next_cycle();
      CPU_WE = 0;
      #3;
      $display("cpu read addr=10");
      chk("cpur_rdata", CPU_RDATA, 8'h5A);
      chk("cpur_mwe", MEM_WE, 0);
      chk("cpur_stall", CPU_STALL, 0);
      next_cycle();

      // Host in idle cycles: read then write
      CPU_EN = 0; H_REQ = 1; H_WE = 0; H_ADDR = 8'h10;
      #3;
      $display("host read addr=10 (cpu idle)");
      chk("hr_gnt", H_GNT, 1);
      chk("hr_rdata", H_RDATA, 8'h5A);
      chk("hr_addr", MEM_ADDR, 8'h10);
      chk("hr_stall", CPU_STALL, 0);
      next_cycle();
      H_WE = 1; H_ADDR = 8'h20; H_WDATA = 8'hC3;
      #3;
      $display("host write addr=20 data=C3 (cpu idle)");
      chk("hw_gnt", H_GNT, 1);
      chk("hw_mwe", MEM_WE, 1);
      chk("hw_wdata", MEM_WDATA, 8'hC3);
      next_cycle();
      H_REQ = 0; H_WE = 0; CPU_EN = 1; CPU_ADDR = 8'h20;
      #3;
      $display("cpu read addr=20");
      chk("cpur2_rdata", CPU_RDATA, 8'hC3);
      chk("cpur2_gnt", H_GNT, 0);
      next_cycle();

      // Starvation: host forced in every 5th cycle
      CPU_EN = 1; CPU_WE = 0; CPU_ADDR = 8'h10;
      H_REQ = 1; H_LOCK = 0; H_WE = 0; H_ADDR = 8'h20;
      for (int i = 0; i < 15; i++) begin
         #3;
         $display("starve cycle %0d gnt=%0b stall=%0b", i, H_GNT, CPU_STALL);
         chk($sformatf("starve_gnt%0d", i), H_GNT, (i % 5 == 4) ? 1 : 0);
         chk($sformatf("starve_stall%0d", i), CPU_STALL, (i % 5 == 4) ? 1 : 0);
         chk($sformatf("starve_addr%0d", i), MEM_ADDR, (i % 5 == 4) ? 8'h20 : 8'h10);
         next_cycle();
      end

      // Host drops request just before it would starve: wait count must clear
      for (int i = 0; i < 3; i++) next_cycle();
      H_REQ = 0;
      #3;
      $display("host request dropped at wait=3");
      chk("drop_gnt", H_GNT, 0);
      next_cycle();
      H_REQ = 1;
      for (int i = 0; i < 5; i++) begin
         #3;
         $display("after drop cycle %0d gnt=%0b", i, H_GNT);
         chk($sformatf("drop_gnt%0d", i), H_GNT, (i == 4) ? 1 : 0);
         next_cycle();
      end

      // 50-cycle starvation run for the stall statistic
`ifdef D_MEM_ARB_STATS_EN
      stall_base = STALL_CNT;
`endif
      for (int i = 0; i < 50; i++) begin
         #3;
         chk($sformatf("run50_gnt%0d", i), H_GNT, (i % 5 == 4) ? 1 : 0);
         next_cycle();
      end
      $display("50-cycle starvation run done");
`ifdef D_MEM_ARB_STATS_EN
      #3;
      chk("stall_cnt_50", STALL_CNT, stall_base + 16'd10);
      next_cycle();
      for (int i = 0; i < 4; i++) next_cycle();
`endif

      // Locked burst: 4 CPU cycles, forced grant, 8 locked cycles, 4 CPU cycles, grant
      H_LOCK = 1; H_REQ = 1; CPU_EN = 1;
      for (int i = 0; i < 18; i++) begin
         #3;
         $display("burst cycle %0d gnt=%0b stall=%0b", i, H_GNT, CPU_STALL);
         chk($sformatf("burst_gnt%0d", i), H_GNT, ((i >= 4 && i <= 12) || i == 17) ? 1 : 0);
         chk($sformatf("burst_stall%0d", i), CPU_STALL, ((i >= 4 && i <= 12) || i == 17) ? 1 : 0);
         next_cycle();
      end
      // Now locked: dropping H_LOCK still grants this cycle, then releases
      H_LOCK = 0;
      #3;
      $display("lock released by host");
      chk("unlock_gnt", H_GNT, 1);
      next_cycle();
      #3;
      chk("unlock_next_gnt", H_GNT, 0);
      chk("unlock_next_stall", CPU_STALL, 0);
      next_cycle();

      // Reset asserted mid-lock
      CPU_EN = 0; H_REQ = 1; H_LOCK = 1; H_WE = 0;
      next_cycle();
      CPU_EN = 1; H_WE = 1; H_ADDR = 8'h40; H_WDATA = 8'h77;
      #3;
      $display("locked host write addr=40 data=77");
      chk("lockw_gnt", H_GNT, 1);
      chk("lockw_stall", CPU_STALL, 1);
      chk("lockw_mwe", MEM_WE, 1);
      next_cycle();
      H_ADDR = 8'h41; H_WDATA = 8'h99;
      RST_N = 1'b0;
      #3;
      $display("reset asserted mid-lock");
      chk("mrst_gnt", H_GNT, 0);
      chk("mrst_stall", CPU_STALL, 0);
      chk("mrst_mwe", MEM_WE, 0);
      chk("mrst_men", MEM_EN, 0);
`ifdef D_MEM_ARB_STATS_EN
      chk("mrst_stall_cnt", STALL_CNT, 0);
`endif
      next_cycle();
      RST_N = 1'b1;
      H_WE = 0; CPU_WE = 0; CPU_ADDR = 8'h41;
      #3;
      $display("first cycle after reset, cpu read addr=41");
      chk("post_gnt", H_GNT, 0);
      chk("post_stall", CPU_STALL, 0);
      chk("post_addr", MEM_ADDR, 8'h41);
      chk("post_rdata41", CPU_RDATA, 8'h00);
      next_cycle();
      CPU_ADDR = 8'h40;
      #3;
      $display("cpu read addr=40");
      chk("post_rdata40", CPU_RDATA, 8'h77);
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/d_mem_arb.md
Name: d_mem_arb

Overview:
- Arbiter sharing the single-port data memory between the one-cycle CPU datapath (EN_D_MEM / D_MEM_ADDR from cpu_ctrl) and a host/loader port.
- CPU has default priority. The host wins idle cycles, and wins forced slots after a bounded wait, with CPU_STALL freezing the PC.
- The host may lock the memory for a bounded burst.
- Memory: asynchronous read, synchronous write on CLK rising edge.

Parameters:
AW, 8, address width (matches D_MEM_ADDR)
DW, 8, data width
MAX_WAIT, 4, consecutive denied host-request cycles before a forced host slot (>=1)
MAX_BURST, 8, maximum consecutive locked host cycles (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
CPU_EN  in  1  CPU memory access this cycle (EN_D_MEM)
CPU_WE  in  1  CPU write (1) / read (0)
CPU_ADDR  in  AW  CPU address
CPU_WDATA  in  DW  CPU write data
CPU_RDATA  out  DW  read data to CPU
CPU_STALL  out  1  CPU access not serviced; hold PC, suppress ACC/REG_F update
H_REQ  in  1  host request
H_LOCK  in  1  host requests burst ownership
H_WE  in  1  host write/read
H_ADDR  in  AW  host address
H_WDATA  in  DW  host write data
H_GNT  out  1  host access performed this cycle
H_RDATA  out  DW  read data to host, valid when H_GNT=1
MEM_EN  out  1  memory access enable
MEM_WE  out  1  memory write enable
MEM_ADDR  out  AW  memory address
MEM_WDATA  out  DW  memory write data
MEM_RDATA  in  DW  memory read data

Behaviour:
- State: FSM {ARB, LOCK}, wait_cnt (0..MAX_WAIT, saturating), burst_cnt (0..MAX_BURST). Counter widths are $clog2(max+1).
- Reset (RST_N low, async):
  - state=ARB, wait_cnt=0, burst_cnt=0.
  - While RST_N is low, H_GNT=0, CPU_STALL=0, MEM_EN=0, MEM_WE=0.
- starve = (wait_cnt==MAX_WAIT).
- ARB state, host_win = H_REQ & (~CPU_EN | starve):
  - host_win: H_GNT=1; MEM_* from host signals; CPU_STALL=CPU_EN.
  - otherwise: H_GNT=0; MEM_* from CPU signals; CPU_STALL=0.
  - MEM_EN = granted requester's enable. MEM_WE = granted requester's WE & MEM_EN.
  - wait_cnt next:
    - 0 if host_win or ~H_REQ;
    - else if CPU_EN, +1 saturating at MAX_WAIT.
  - On host_win & H_LOCK: next state LOCK, burst_cnt=1. Otherwise stay in ARB, burst_cnt=0.
- LOCK state:
  - Memory is owned by the host. H_GNT=H_REQ. MEM_EN=H_REQ. CPU_STALL=CPU_EN.
  - Exit to ARB (burst_cnt=0, wait_cnt=0) at the clock edge ending a cycle where ~H_REQ | ~H_LOCK | burst_cnt==MAX_BURST. Otherwise burst_cnt+1.
  - After a forced release at MAX_BURST, the CPU owns the next ARB cycle when CPU_EN=1, because wait_cnt=0.
- Read data: CPU_RDATA = H_RDATA = MEM_RDATA (combinational, zero latency). The value is meaningful only to the current grantee.
- Simultaneous events:
  - CPU_EN & H_REQ with wait_cnt<MAX_WAIT: CPU served.
  - H_REQ dropping in the same cycle wait_cnt would reach MAX_WAIT: counter clears.
- A stalled CPU re-presents the same access next cycle. The arbiter keeps no CPU-side state.
- Reset asserted mid-LOCK: immediate return to ARB with counters cleared. Any write in flight that cycle is suppressed (MEM_WE=0).
- No combinational path from outputs back to the H_*/CPU_* inputs beyond the stated muxing.

Optional Feature:
- Macro D_MEM_ARB_STATS_EN.
- Defined: extra output port STALL_CNT [15:0].
  - Counts cycles with CPU_STALL=1, saturating at 16'hFFFF.
  - Cleared by RST_N.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive RST_N=0 mid-LOCK with H_REQ=1, CPU_EN=1 -> same cycle H_GNT=0, CPU_STALL=0, MEM_WE=0. After release, state=ARB and the first CPU_EN cycle is served.
- CPU only: CPU_EN=1, CPU_WE=1, ADDR=8'h10, WDATA=8'h5A, then read 8'h10 -> MEM_WE=1 on cycle 1; CPU_RDATA=8'h5A on cycle 2; CPU_STALL=0 throughout.
- Idle host: CPU_EN=0, H_REQ=1, H_WE=0, H_ADDR=8'h10 -> H_GNT=1 the same cycle, H_RDATA=8'h5A.
- Starvation: CPU_EN=1 and H_REQ=1 held continuously, MAX_WAIT=4 -> CPU served for 4 cycles; 5th cycle H_GNT=1, CPU_STALL=1; then the pattern repeats with period 5.
- Burst: H_LOCK=1, H_REQ=1 for 12 cycles, CPU_EN=1, MAX_BURST=8 -> after the forced grant, H_GNT=1 and CPU_STALL=1 for exactly 8 cycles. Next cycle CPU served (H_GNT=0); the host waits 4 more cycles before the next grant.
- Stats (D_MEM_ARB_STATS_EN): run the starvation scenario for 50 cycles -> STALL_CNT=10. Without the macro, the bench compiles without the STALL_CNT port.
